axis_snapshot_burst: RTL
========================

# axis_snapshot_burst

Burst-capture successor to the single-word AXI-Stream snapshot tap. Sits passively on an AXI-Stream link (tready passes straight through), and on an arm pulse records 2^DEPTH_WIDTH accepted beats into an internal buffer. An optional decimation factor sets which beats are recorded. The buffer is read back through a synchronous address port by the register/bus side, and the most recent recorded word stays visible on `data`.

## Interface
- AXIS_TDATA_WIDTH, 32, sample width in bits
- DEPTH_WIDTH, 4, log2 of buffer depth (DEPTH = 2^DEPTH_WIDTH words)
- DECIM_WIDTH, 16, width of decimation setting

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, asynchronous assert, active-low
- s_axis_tdata  in  AXIS_TDATA_WIDTH  monitored stream data
- s_axis_tvalid  in  1  monitored stream valid
- s_axis_tready  out  1  equals m_axis_tready (combinational)
- m_axis_tready  in  1  downstream ready
- arm  in  1  single-cycle pulse; starts or restarts a burst
- cfg_decim  in  DECIM_WIDTH  record every (cfg_decim+1)-th accepted beat; sampled at arm
- rd_addr  in  DEPTH_WIDTH  buffer read address
- rd_data  out  AXIS_TDATA_WIDTH  buffer word at rd_addr, registered
- data  out  AXIS_TDATA_WIDTH  last recorded word
- count  out  DEPTH_WIDTH+1  words recorded in current burst
- busy  out  1  burst in progress
- done  out  1  burst complete, buffer full

## Operation
- Accepted beat: `s_axis_tvalid & m_axis_tready`. The block never stalls the stream.
- State machine: IDLE, CAPTURE, DONE. Reset enters IDLE.
- IDLE: `busy=0`, `done=0`. An `arm` pulse moves to CAPTURE. It also clears the write pointer, `count`, and the decimation counter, and latches `cfg_decim`.
- CAPTURE: `busy=1`. On each accepted beat:
  - If the decimation counter is 0: write `s_axis_tdata` to buffer[wr_ptr], copy it to `data`, and increment wr_ptr and `count`.
  - The decimation counter then wraps to 0 if it equals the latched decim, otherwise it increments.
  - When the written word is at index DEPTH-1, move to DONE.
- DONE: `busy=0`, `done=1`, `count=DEPTH`. Buffer and `data` hold. `arm` restarts the burst (same actions as from IDLE).
- `arm` during CAPTURE restarts immediately. Pointer, `count` and decimation counter clear, `done` stays 0, and new `cfg_decim` is latched. Old buffer contents are overwritten progressively.
- `arm` coinciding with the final recorded beat: arm wins. That beat is not recorded, the state stays CAPTURE with `count=0`, and `done` is never asserted.
- A beat accepted in the same cycle as `arm` is not recorded. Recording starts with the next accepted beat.
- `cfg_decim=0`: every accepted beat is recorded. `cfg_decim` changes outside arm have no effect.
- Read port: `rd_data` is buffer[rd_addr] registered, one-cycle latency. It is valid in any state.
- Read and write to the same address in one cycle: `rd_data` returns the old contents.
- Buffer contents are not reset. Only entries written since reset are defined.

## Timing
- Reset values: `data=0`, `count=0`, `busy=0`, `done=0`, `rd_data=0`.
- `s_axis_tready` follows `m_axis_tready` with zero latency, including during reset.
- `arm` at cycle n: `busy=1` at n+1.
- A recorded beat at cycle n updates `data`, `count` and the buffer at n+1.
- The final recorded beat at cycle n gives `done=1` and `busy=0` at n+1.
- `rd_addr` applied at cycle n gives `rd_data` at n+1.
- Reset mid-burst: on `aresetn` low, all outputs go to their reset values asynchronously and the state returns to IDLE. Recording resumes only after a new `arm`.

## Test plan
- Default parameters, `cfg_decim=0`, arm, then 16 consecutive beats of data 0x100..0x10F with tready=1 -> `done=1` one cycle after the 16th beat, `count=16`, `data=0x10F`; readback of addresses 0..15 returns 0x100..0x10F.
- `cfg_decim=2`, 48 beats of data 0..47 -> buffer holds 0,3,6,…,45; `done` rises the cycle after beat 45; beats 46 and 47 are ignored.
- Random tvalid/tready gaps (about 50% each) -> only cycles where both are high are recorded; `s_axis_tready` always equals `m_axis_tready`.
- Re-arm after 5 recorded words, then 16 more beats -> `count` drops to 0 the cycle after arm, and the buffer holds the post-arm data only. Also arm exactly on the 16th beat -> `done` stays 0 and `count=0`.
- Deassert `aresetn` for 2 cycles asynchronously (between clock edges) mid-burst -> outputs reset immediately; subsequent beats without arm leave `count=0` and `busy=0`.
- Read address 3 in the same cycle it is being written -> `rd_data` shows the previous value, then the new value on the following read.

Source files
------------

// File: rtl/axis_snapshot_burst.sv
// axis_snapshot_burst
//   Passive AXI-Stream tap. An arm pulse captures a burst of 2^DEPTH_WIDTH
//   accepted beats, optionally decimated, into an internal buffer that is
//   read back through a registered synchronous read port.
//
// Ports
//   aclk, aresetn   clock, asynchronous active-low reset
//   s_axis_tdata    monitored stream data
//   s_axis_tvalid   monitored stream valid
//   s_axis_tready   pass-through of m_axis_tready
//   m_axis_tready   downstream ready
//   arm             single-cycle pulse, starts/restarts a burst
//   cfg_decim       record every (cfg_decim+1)-th accepted beat, sampled at arm
//   rd_addr         buffer read address
//   rd_data         buffer[rd_addr], one cycle latency
//   data            last recorded word
//   count           words recorded in the current burst
//   busy            burst in progress
//   done            burst complete, buffer full
module axis_snapshot_burst #(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned DEPTH_WIDTH      = 4,
  parameter int unsigned DECIM_WIDTH      = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        m_axis_tready,
  input  logic                        arm,
  input  logic [DECIM_WIDTH-1:0]      cfg_decim,
  input  logic [DEPTH_WIDTH-1:0]      rd_addr,
  output logic [AXIS_TDATA_WIDTH-1:0] rd_data,
  output logic [AXIS_TDATA_WIDTH-1:0] data,
  output logic [DEPTH_WIDTH:0]        count,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [DEPTH_WIDTH-1:0]      wr_ptr_q;
  logic [DEPTH_WIDTH:0]        count_q;
  logic [DECIM_WIDTH-1:0]      decim_cnt_q;
  logic [DECIM_WIDTH-1:0]      decim_lat_q;
  logic [AXIS_TDATA_WIDTH-1:0] data_q;
  logic [AXIS_TDATA_WIDTH-1:0] rd_data_q;
  logic [AXIS_TDATA_WIDTH-1:0] mem [DEPTH];

  logic beat;
  logic rec;

  assign s_axis_tready = m_axis_tready;
  assign beat          = s_axis_tvalid & m_axis_tready;
  // arm has priority over a coincident beat, so that beat is never recorded
  assign rec           = (state_q == ST_CAPTURE) && beat && !arm && (decim_cnt_q == '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (arm) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (arm)                         state_d = ST_CAPTURE;
        else if (rec && wr_ptr_q == '1)  state_d = ST_DONE;
      end
      ST_DONE:    if (arm) state_d = ST_CAPTURE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      decim_cnt_q <= '0;
      decim_lat_q <= '0;
      data_q      <= '0;
    end else if (arm) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      decim_cnt_q <= '0;
      decim_lat_q <= cfg_decim;
    end else if (state_q == ST_CAPTURE && beat) begin
      if (decim_cnt_q == decim_lat_q) decim_cnt_q <= '0;
      else                            decim_cnt_q <= decim_cnt_q + DECIM_WIDTH'(1);
      if (rec) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_WIDTH'(1);
        count_q  <= count_q + (DEPTH_WIDTH+1)'(1);
        data_q   <= s_axis_tdata;
      end
    end
  end

  // Buffer is intentionally unreset; read returns pre-write contents on collision.
  always_ff @(posedge aclk) begin
    if (rec) mem[wr_ptr_q] <= s_axis_tdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rd_data_q <= '0;
    else          rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;
  assign data    = data_q;
  assign count   = count_q;
  assign busy    = (state_q == ST_CAPTURE);
  assign done    = (state_q == ST_DONE);

endmodule
